// File: rtl/seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// seq_ctrl_if -- bundle between the sequential Y86 controller and its datapath.
//
// Signals
//   start                     request to leave IDLE and run from PC
//   icode, hlt, imem_error,   fetch-stage results for the instruction at PC
//   instr_valid
//   valP, valC, valM          fall-through PC, constant word, memory read value
//   cnd                       branch condition from execute
//   dmem_error                data-memory address fault
//   PC                        registered program counter to fetch
//   fetch_en..wb_en           one-hot stage strobes
//   stat                      Y86 status (1=AOK 2=HLT 3=ADR 4=INS)
//   busy                      controller is executing (not IDLE/HALT)
//   state                     FSM state, exposed for observation
//
// Handshake: there is no ready/back-pressure path. instr_valid is a
// qualifier, not a request: the controller samples it together with the
// other fetch flags on the last clock of FETCH. The datapath must present
// stable fetch results for the current PC whenever fetch_en is high, and
// the controller never stalls.
//
// Modports: master = controller side, slave = datapath side.
// ---------------------------------------------------------------------------
interface seq_ctrl_if;
    logic        start;
    logic [3:0]  icode;
    logic        hlt;
    logic        imem_error;
    logic        instr_valid;
    logic [63:0] valP;
    logic [63:0] valC;
    logic [63:0] valM;
    logic        cnd;
    logic        dmem_error;
    logic [63:0] PC;
    logic        fetch_en;
    logic        decode_en;
    logic        exec_en;
    logic        mem_en;
    logic        wb_en;
    logic [2:0]  stat;
    logic        busy;
    logic [2:0]  state;

    modport master (
        input  start, icode, hlt, imem_error, instr_valid,
        input  valP, valC, valM, cnd, dmem_error,
        output PC, fetch_en, decode_en, exec_en, mem_en, wb_en,
        output stat, busy, state
    );

    modport slave (
        output start, icode, hlt, imem_error, instr_valid,
        output valP, valC, valM, cnd, dmem_error,
        input  PC, fetch_en, decode_en, exec_en, mem_en, wb_en,
        input  stat, busy, state
    );
endinterface

// File: rtl/seq_ctrl.sv
// ---------------------------------------------------------------------------
// seq_ctrl -- sequential (non-pipelined) Y86-64 stage sequencer.
//
// Walks IDLE -> FETCH -> DECODE -> EXECUTE -> MEMORY -> WRITEBACK -> PCUPD
// -> FETCH ..., one cycle per state, and stops in a sticky HALT on a fetch
// fault, an invalid instruction, a halt instruction or a data-memory fault.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   bus         seq_ctrl_if.master (fetch/execute inputs, PC, strobes, stat)
//   cycle_cnt   (SEQ_CTRL_PERF_EN only) cycles spent with busy=1
//   instr_cnt   (SEQ_CTRL_PERF_EN only) instructions retired through PCUPD
//
// Parameter
//   RESET_PC    PC value loaded on reset
//
// Build option: define SEQ_CTRL_PERF_EN to add the performance counters.
// ---------------------------------------------------------------------------
module seq_ctrl #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic           clk,
    input  logic           rst_n,
    seq_ctrl_if.master     bus
`ifdef SEQ_CTRL_PERF_EN
    ,
    output logic [63:0]    cycle_cnt,
    output logic [63:0]    instr_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_PCUPD     = 3'd6,
        S_HALT      = 3'd7
    } state_t;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [3:0] I_JXX  = 4'h7;
    localparam logic [3:0] I_CALL = 4'h8;
    localparam logic [3:0] I_RET  = 4'h9;

    state_t      st;
    logic [63:0] pc_q;
    logic [63:0] pc_next;
    logic [2:0]  stat_q;
    logic        busy_q;
    logic        fetch_q, decode_q, exec_q, mem_q, wb_q;

    // Next-PC select, only consumed in PCUPD.
    always_comb begin
        pc_next = bus.valP;
        if ((bus.icode == I_JXX && bus.cnd) || bus.icode == I_CALL) begin
            pc_next = bus.valC;
        end else if (bus.icode == I_RET) begin
            pc_next = bus.valM;
        end
    end

    // Strobes and busy are registered alongside the state so they change on
    // the same edge the state does. Each branch sets the strobe for the state
    // it is entering; everything else defaults to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st       <= S_IDLE;
            pc_q     <= RESET_PC;
            stat_q   <= STAT_AOK;
            busy_q   <= 1'b0;
            fetch_q  <= 1'b0;
            decode_q <= 1'b0;
            exec_q   <= 1'b0;
            mem_q    <= 1'b0;
            wb_q     <= 1'b0;
        end else begin
            fetch_q  <= 1'b0;
            decode_q <= 1'b0;
            exec_q   <= 1'b0;
            mem_q    <= 1'b0;
            wb_q     <= 1'b0;
            case (st)
                S_IDLE: begin
                    if (bus.start) begin
                        st      <= S_FETCH;
                        fetch_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (bus.imem_error) begin
                        stat_q <= STAT_ADR;
                        st     <= S_HALT;
                        busy_q <= 1'b0;
                    end else if (!bus.instr_valid) begin
                        stat_q <= STAT_INS;
                        st     <= S_HALT;
                        busy_q <= 1'b0;
                    end else if (bus.hlt) begin
                        stat_q <= STAT_HLT;
                        st     <= S_HALT;
                        busy_q <= 1'b0;
                    end else begin
                        st       <= S_DECODE;
                        decode_q <= 1'b1;
                    end
                end
                S_DECODE: begin
                    st     <= S_EXECUTE;
                    exec_q <= 1'b1;
                end
                S_EXECUTE: begin
                    st    <= S_MEMORY;
                    mem_q <= 1'b1;
                end
                S_MEMORY: begin
                    // A data fault kills the instruction before writeback.
                    if (bus.dmem_error) begin
                        stat_q <= STAT_ADR;
                        st     <= S_HALT;
                        busy_q <= 1'b0;
                    end else begin
                        st   <= S_WRITEBACK;
                        wb_q <= 1'b1;
                    end
                end
                S_WRITEBACK: begin
                    st <= S_PCUPD;
                end
                S_PCUPD: begin
                    pc_q    <= pc_next;
                    st      <= S_FETCH;
                    fetch_q <= 1'b1;
                end
                S_HALT: begin
                    st <= S_HALT;
                end
                default: begin
                    st     <= S_HALT;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.PC        = pc_q;
    assign bus.stat      = stat_q;
    assign bus.busy      = busy_q;
    assign bus.fetch_en  = fetch_q;
    assign bus.decode_en = decode_q;
    assign bus.exec_en   = exec_q;
    assign bus.mem_en    = mem_q;
    assign bus.wb_en     = wb_q;
    assign bus.state     = st;

`ifdef SEQ_CTRL_PERF_EN
    // busy_q is already 0 in HALT, so both counters freeze there naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= 64'd0;
            instr_cnt <= 64'd0;
        end else begin
            if (busy_q) begin
                cycle_cnt <= cycle_cnt + 64'd1;
            end
            if (st == S_PCUPD) begin
                instr_cnt <= instr_cnt + 64'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seq_ctrl -- directed self-checking bench for seq_ctrl.
// Build with SEQ_CTRL_PERF_EN defined to also exercise the counters.
// ---------------------------------------------------------------------------
module tb_seq_ctrl;
    localparam logic [63:0] RST_PC = 64'h1000;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;
    logic wb_seen;

    seq_ctrl_if bus ();

`ifdef SEQ_CTRL_PERF_EN
    logic [63:0] cycle_cnt;
    logic [63:0] instr_cnt;
    seq_ctrl #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
    );
`else
    seq_ctrl #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
`endif

    wire [4:0] strb = {bus.fetch_en, bus.decode_en, bus.exec_en, bus.mem_en, bus.wb_en};

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are then sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_defaults();
        bus.start = 1'b0; bus.icode = 4'h0; bus.hlt = 1'b0;
        bus.imem_error = 1'b0; bus.instr_valid = 1'b1;
        bus.valP = 64'h0; bus.valC = 64'h0; bus.valM = 64'h0;
        bus.cnd = 1'b0; bus.dmem_error = 1'b0;
    endtask

    task automatic do_reset();
        set_defaults();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #2;
    endtask

    // From IDLE: start, walk FETCH..PCUPD, land in the next FETCH.
    task automatic run_one(input logic [3:0] ic, input logic c,
                           input logic [63:0] p, input logic [63:0] k,
                           input logic [63:0] m);
        bus.icode = ic; bus.cnd = c; bus.valP = p; bus.valC = k; bus.valM = m;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        set_defaults();
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
        #1;
        vectors++; if (bus.PC !== RST_PC) begin $display("FAIL reset_pc got %h exp %h", bus.PC, RST_PC); miscompares++; end
        vectors++; if (bus.stat !== 3'd1) begin $display("FAIL reset_stat got %0d exp 1", bus.stat); miscompares++; end
        vectors++; if ({strb, bus.busy} !== 6'b0) begin $display("FAIL reset_strobes_busy got %b exp 000000", {strb, bus.busy}); miscompares++; end
        vectors++; if (bus.state !== 3'd0) begin $display("FAIL reset_state got %0d exp 0", bus.state); miscompares++; end
        tick();
        rst_n = 1'b1;
        #2;
    endtask

    task automatic test_basic();
        logic [4:0] exp_s;
        do_reset();
        bus.icode = 4'h6; bus.valP = 64'h2; bus.start = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            bus.start = 1'b0;
            exp_s = 5'b10000 >> (i - 1);
            vectors++; if (strb !== exp_s || bus.busy !== 1'b1) begin $display("FAIL basic_strobe_c%0d got %b busy %b exp %b busy 1", i, strb, bus.busy, exp_s); miscompares++; end
            vectors++; if (bus.PC !== RST_PC) begin $display("FAIL basic_pc_hold_c%0d got %h exp %h", i, bus.PC, RST_PC); miscompares++; end
        end
        tick();
        vectors++; if (strb !== 5'b0 || bus.state !== 3'd6 || bus.busy !== 1'b1) begin $display("FAIL basic_pcupd got strb %b state %0d busy %b exp 00000 6 1", strb, bus.state, bus.busy); miscompares++; end
        tick();
        vectors++; if (bus.PC !== 64'h2) begin $display("FAIL basic_pc got %h exp 2", bus.PC); miscompares++; end
        vectors++; if (bus.stat !== 3'd1 || strb !== 5'b10000) begin $display("FAIL basic_refetch got stat %0d strb %b exp 1 10000", bus.stat, strb); miscompares++; end
    endtask

    task automatic test_branch();
        do_reset();
        run_one(4'h7, 1'b1, 64'h9, 64'h40, 64'h77);
        vectors++; if (bus.PC !== 64'h40) begin $display("FAIL jxx_taken got %h exp 40", bus.PC); miscompares++; end
        do_reset();
        run_one(4'h7, 1'b0, 64'h9, 64'h40, 64'h77);
        vectors++; if (bus.PC !== 64'h9) begin $display("FAIL jxx_not_taken got %h exp 9", bus.PC); miscompares++; end
        do_reset();
        run_one(4'h6, 1'b1, 64'h9, 64'h40, 64'h77);
        vectors++; if (bus.PC !== 64'h9) begin $display("FAIL opq_cnd_ignored got %h exp 9", bus.PC); miscompares++; end
    endtask

    task automatic test_call_ret();
        do_reset();
        run_one(4'h8, 1'b0, 64'h9, 64'h100, 64'h23);
        vectors++; if (bus.PC !== 64'h100) begin $display("FAIL call got %h exp 100", bus.PC); miscompares++; end
        do_reset();
        run_one(4'h9, 1'b0, 64'h9, 64'h100, 64'h23);
        vectors++; if (bus.PC !== 64'h23) begin $display("FAIL ret got %h exp 23", bus.PC); miscompares++; end
    endtask

    // Full-width PC, then the wrapped fall-through on the next instruction.
    task automatic test_back_to_back();
        do_reset();
        run_one(4'h6, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h5, 64'h5);
        vectors++; if (bus.PC !== 64'hFFFF_FFFF_FFFF_FFFF) begin $display("FAIL pc_full_width got %h exp ffffffffffffffff", bus.PC); miscompares++; end
        bus.valP = 64'h0;
        for (int i = 0; i < 6; i++) tick();
        vectors++; if (bus.PC !== 64'h0 || strb !== 5'b10000) begin $display("FAIL pc_wrap got %h strb %b exp 0 10000", bus.PC, strb); miscompares++; end
    endtask

    task automatic test_fetch_fault();
        do_reset();
        bus.imem_error = 1'b1; bus.instr_valid = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        vectors++; if (bus.stat !== 3'd3) begin $display("FAIL fetch_adr_stat got %0d exp 3", bus.stat); miscompares++; end
        vectors++; if (bus.state !== 3'd7 || bus.busy !== 1'b0 || strb !== 5'b0) begin $display("FAIL fetch_adr_halt got state %0d busy %b strb %b exp 7 0 00000", bus.state, bus.busy, strb); miscompares++; end
        vectors++; if (bus.PC !== RST_PC) begin $display("FAIL fetch_adr_pc got %h exp %h", bus.PC, RST_PC); miscompares++; end
        bus.start = 1'b1; bus.imem_error = 1'b0; bus.instr_valid = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        bus.start = 1'b0;
        vectors++; if (bus.stat !== 3'd3 || bus.state !== 3'd7 || strb !== 5'b0) begin $display("FAIL halt_sticky got stat %0d state %0d strb %b exp 3 7 00000", bus.stat, bus.state, strb); miscompares++; end
        do_reset();
        bus.instr_valid = 1'b0; bus.hlt = 1'b1; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        vectors++; if (bus.stat !== 3'd4) begin $display("FAIL fetch_ins_stat got %0d exp 4", bus.stat); miscompares++; end
        do_reset();
        bus.hlt = 1'b1; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        vectors++; if (bus.stat !== 3'd2 || bus.state !== 3'd7 || bus.PC !== RST_PC) begin $display("FAIL fetch_hlt got stat %0d state %0d pc %h exp 2 7 %h", bus.stat, bus.state, bus.PC, RST_PC); miscompares++; end
    endtask

    task automatic test_dmem_fault();
        do_reset();
        wb_seen = 1'b0;
        bus.icode = 4'h5; bus.valP = 64'h33; bus.dmem_error = 1'b1; bus.start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            bus.start = 1'b0;
            wb_seen = wb_seen | bus.wb_en;
        end
        vectors++; if (strb !== 5'b00010) begin $display("FAIL dmem_in_memory got %b exp 00010", strb); miscompares++; end
        for (int i = 0; i < 5; i++) begin
            tick();
            wb_seen = wb_seen | bus.wb_en;
        end
        vectors++; if (bus.stat !== 3'd3 || bus.state !== 3'd7) begin $display("FAIL dmem_stat got stat %0d state %0d exp 3 7", bus.stat, bus.state); miscompares++; end
        vectors++; if (wb_seen !== 1'b0) begin $display("FAIL dmem_no_wb got %b exp 0", wb_seen); miscompares++; end
        vectors++; if (bus.PC !== RST_PC) begin $display("FAIL dmem_pc got %h exp %h", bus.PC, RST_PC); miscompares++; end

        // New run from a clean state, then a reset pulse in the EXECUTE cycle.
        do_reset();
        run_one(4'h6, 1'b0, 64'h50, 64'h0, 64'h0);
        tick();
        tick();
        vectors++; if (bus.PC !== 64'h50 || strb !== 5'b00100) begin $display("FAIL pre_reset_execute got pc %h strb %b exp 50 00100", bus.PC, strb); miscompares++; end
        bus.start = 1'b1;
        rst_n = 1'b0;
        #1;
        vectors++; if (bus.PC !== RST_PC || bus.stat !== 3'd1 || bus.state !== 3'd0) begin $display("FAIL midexec_reset got pc %h stat %0d state %0d exp %h 1 0", bus.PC, bus.stat, bus.state, RST_PC); miscompares++; end
        vectors++; if ({strb, bus.busy} !== 6'b0) begin $display("FAIL midexec_reset_strobes got %b exp 000000", {strb, bus.busy}); miscompares++; end
        tick();
        vectors++; if (bus.state !== 3'd0) begin $display("FAIL start_in_reset got state %0d exp 0", bus.state); miscompares++; end
        rst_n = 1'b1;
        #2;
        tick();
        bus.start = 1'b0;
        vectors++; if (bus.state !== 3'd1 || strb !== 5'b10000 || bus.PC !== RST_PC) begin $display("FAIL first_edge_after_reset got state %0d strb %b pc %h exp 1 10000 %h", bus.state, strb, bus.PC, RST_PC); miscompares++; end
    endtask

`ifdef SEQ_CTRL_PERF_EN
    task automatic test_perf();
        do_reset();
        vectors++; if (cycle_cnt !== 64'd0 || instr_cnt !== 64'd0) begin $display("FAIL perf_reset got %0d %0d exp 0 0", cycle_cnt, instr_cnt); miscompares++; end
        bus.icode = 4'h1; bus.valP = 64'h1001; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 18; i++) tick();
        bus.hlt = 1'b1;
        tick();
        vectors++; if (bus.stat !== 3'd2) begin $display("FAIL perf_halt got stat %0d exp 2", bus.stat); miscompares++; end
        vectors++; if (instr_cnt !== 64'd3) begin $display("FAIL perf_instr_cnt got %0d exp 3", instr_cnt); miscompares++; end
        vectors++; if (cycle_cnt !== 64'd19) begin $display("FAIL perf_cycle_cnt got %0d exp 19", cycle_cnt); miscompares++; end
        for (int i = 0; i < 6; i++) tick();
        vectors++; if (cycle_cnt !== 64'd19 || instr_cnt !== 64'd3) begin $display("FAIL perf_frozen got %0d %0d exp 19 3", cycle_cnt, instr_cnt); miscompares++; end
    endtask
`endif

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        set_defaults();
        test_reset();
        test_basic();
        test_branch();
        test_call_ret();
        test_back_to_back();
        test_fetch_fault();
        test_dmem_fault();
`ifdef SEQ_CTRL_PERF_EN
        test_perf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/seq_ctrl.md
SEQ_CTRL -- requirements
Module: seq_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, the PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port start  input  1  leave IDLE and begin executing at PC.
REQ-005 SHALL have port icode  input  4  instruction code from fetch stage.
REQ-006 SHALL have port hlt, imem_error, instr_valid  input  1 each  fetch-stage status flags.
REQ-007 SHALL have port valP, valC, valM  input  64 each  fall-through PC, constant word, memory read value.
REQ-008 SHALL have port cnd  input  1  branch condition from execute stage.
REQ-009 SHALL have port dmem_error  input  1  data-memory address fault.
REQ-010 SHALL have port PC  output  64  registered program counter fed to fetch.
REQ-011 SHALL have ports fetch_en, decode_en, exec_en, mem_en, wb_en  output  1 each  one-hot stage strobes.
REQ-012 SHALL have port stat  output  3  Y86 status: 1=AOK, 2=HLT, 3=ADR, 4=INS.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE and HALT.

Function
REQ-014 SHALL implement states IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALT; each non-terminal state lasts exactly one cycle.
REQ-015 SHALL move IDLE->FETCH on the first clock edge with start=1; start SHALL be ignored in all other states.
REQ-016 SHALL assert exactly one stage strobe while in the corresponding state (FETCH..WRITEBACK); all strobes SHALL be 0 in IDLE, PCUPD and HALT.
REQ-017 SHALL sample fetch flags at the end of FETCH with priority imem_error (stat=3) > !instr_valid (stat=4) > hlt (stat=2), and go to HALT if any applies; otherwise go to DECODE.
REQ-018 SHALL sample dmem_error at the end of MEMORY; if set, stat=3, go to HALT, and skip WRITEBACK (wb_en never asserted for that instruction).
REQ-019 SHALL in PCUPD load PC with: valC if icode=4'h7 and cnd=1; valC if icode=4'h8; valM if icode=4'h9; valP otherwise; then go to FETCH.
REQ-020 SHALL hold PC unchanged in every state except PCUPD; a faulting or halting instruction SHALL leave PC pointing at itself.
REQ-021 SHALL keep stat=1 until a fault or halt, after which HALT is sticky until reset; stat SHALL be stable while in HALT.
REQ-022 SHALL perform all PC arithmetic/selection at 64 bits with no truncation; a valP wrap from 64'hFFFF_FFFF_FFFF_FFFF to 0 SHALL be loaded as-is.

Reset
REQ-023 SHALL on rst_n=0, immediately and independent of clk: state=IDLE, PC=RESET_PC, stat=1, all strobes=0, busy=0.
REQ-024 SHALL on reset asserted mid-instruction abandon that instruction with no further strobes and no PC update.
REQ-025 SHALL leave IDLE no earlier than the first rising edge after rst_n deasserts with start=1.

Configuration
REQ-026 SHALL, when SEQ_CTRL_PERF_EN is defined, add outputs cycle_cnt (64) counting every cycle with busy=1 and instr_cnt (64) incremented on each PCUPD, both reset to 0 and frozen in HALT.
REQ-027 SHALL, when SEQ_CTRL_PERF_EN is undefined, omit cycle_cnt and instr_cnt ports and logic entirely, with all other behaviour identical.

Verification
REQ-028 SHALL verify: reset, start=1, icode=6, valP=2 -> strobes FETCH..WRITEBACK on cycles 1..5, PC=2 after cycle 6, stat=1.
REQ-029 SHALL verify: icode=7, cnd=1, valC=64'h40 -> PC=64'h40; same with cnd=0, valP=9 -> PC=9.
REQ-030 SHALL verify: icode=8, valC=64'h100 -> PC=64'h100; icode=9, valM=64'h23 -> PC=64'h23.
REQ-031 SHALL verify: fetch with imem_error=1 and instr_valid=0 together -> stat=3 (ADR), HALT, PC unchanged, busy=0; hlt=1 alone -> stat=2.
REQ-032 SHALL verify: dmem_error=1 in MEMORY -> stat=3, wb_en never pulses, PC unchanged; then rst_n pulse low mid-EXECUTE on a new run -> PC=RESET_PC, stat=1, IDLE.
REQ-033 SHALL verify with SEQ_CTRL_PERF_EN: three icode=1 instructions then hlt -> instr_cnt=3, cycle_cnt=19, both frozen thereafter.
